// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: icache fill port, core data port and memory port.
//   slave  : arbiter view (drives ready/rdata toward requesters, mem_* toward memory)
//   master : environment view (requesters and memory)
//   ic_*   : line-fill request, per-beat fill data, beat index and last flag
//   dm_*   : single-word read/write request and completion
//   mem_*  : shared memory port, one mem_ready pulse per beat
interface mem_arbiter_if #(
    parameter int unsigned LINE_WORDS = 4
);
    localparam int unsigned BW = $clog2(LINE_WORDS);

    logic          ic_req;
    logic [31:0]   ic_addr;
    logic [31:0]   ic_rdata;
    logic          ic_ready;
    logic [BW-1:0] ic_beat;
    logic          ic_last;

    logic          dm_req;
    logic          dm_we;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_wdata;
    logic [3:0]    dm_wstrb;
    logic [31:0]   dm_rdata;
    logic          dm_ready;

    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_rdata;
    logic          mem_ready;

    modport slave (
        input  ic_req, ic_addr,
        output ic_rdata, ic_ready, ic_beat, ic_last,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        output dm_rdata, dm_ready,
        output mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );

    modport master (
        output ic_req, ic_addr,
        input  ic_rdata, ic_ready, ic_beat, ic_last,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        input  dm_rdata, dm_ready,
        input  mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between icache line fills (LINE_WORDS-beat bursts) and the
// core data port (single-word read/write). Alternating priority on contention.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_arbiter_if.slave (ic_*, dm_*, mem_* signal groups)
// mem_* outputs are registered; ready/rdata/beat/last toward requesters are combinational.
module mem_arbiter #(
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned BW = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IC_FILL = 2'd1,
        DM_XFER = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_DM = 1'b0,
        GRANT_IC = 1'b1
    } grant_e;

    state_e        state_q, state_d;
    grant_e        last_grant_q, last_grant_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_wstrb_q, mem_wstrb_d;

    logic          grant_ic;
    logic          grant_dm;
    logic          beat_done;
    logic          last_beat;

    // Byte offsets and in-line word offset of requester addresses are not used.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^{bus.ic_addr[BW+1:0], bus.dm_addr[1:0]};

    // On contention, the side that was not served last wins.
    assign grant_ic  = bus.ic_req && (!bus.dm_req || (last_grant_q == GRANT_DM));
    assign grant_dm  = bus.dm_req && !grant_ic;
    // mem_ready only counts while a request is outstanding.
    assign beat_done = mem_req_q && bus.mem_ready;
    assign last_beat = (beat_q == BW'(LINE_WORDS - 1));

    // Next-state and registered memory-port control.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = mem_we_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;

        case (state_q)
            IDLE: begin
                if (grant_ic) begin
                    state_d     = IC_FILL;
                    beat_d      = '0;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = {bus.ic_addr[31:BW+2], BW'(0), 2'b00};
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = 4'b0000;
                end else if (grant_dm) begin
                    state_d     = DM_XFER;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = {bus.dm_addr[31:2], 2'b00};
                    mem_we_d    = bus.dm_we;
                    mem_wdata_d = bus.dm_wdata;
                    mem_wstrb_d = bus.dm_we ? bus.dm_wstrb : 4'b0000;
                end
            end
            IC_FILL: begin
                if (beat_done) begin
                    if (last_beat) begin
                        state_d      = IDLE;
                        beat_d       = '0;
                        mem_req_d    = 1'b0;
                        last_grant_d = GRANT_IC;
                    end else begin
                        // Next beat issues back-to-back within the latched line.
                        beat_d     = BW'(beat_q + 1'b1);
                        mem_addr_d = {mem_addr_q[31:BW+2], BW'(beat_q + 1'b1), 2'b00};
                    end
                end
            end
            DM_XFER: begin
                if (beat_done) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_wstrb_d  = 4'b0000;
                    last_grant_d = GRANT_DM;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and memory-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_DM;
            beat_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;

    // Completion paths toward requesters; rdata is shared and only meaningful with ready.
    assign bus.ic_ready  = (state_q == IC_FILL) && beat_done;
    assign bus.ic_last   = (state_q == IC_FILL) && beat_done && last_beat;
    assign bus.ic_beat   = beat_q;
    assign bus.ic_rdata  = bus.mem_rdata;
    assign bus.dm_ready  = (state_q == DM_XFER) && beat_done;
    assign bus.dm_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_arbiter_if #(.LINE_WORDS(4)) bus ();

    mem_arbiter #(.LINE_WORDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ic_req    = 1'b0;
        bus.ic_addr   = 32'h0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = 32'h0;
        bus.dm_wdata  = 32'h0;
        bus.dm_wstrb  = 4'h0;
        bus.mem_rdata = 32'h0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.mem_ready = 1'b1;
        cyc();
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_we: mem_req=%b mem_we=%b expected 0 0", bus.mem_req, bus.mem_we);
        end
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h wdata=%h wstrb=%h expected zeros",
                     bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
        end
        checks++;
        if (bus.ic_ready !== 1'b0 || bus.ic_last !== 1'b0 || bus.dm_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: ic_ready=%b ic_last=%b dm_ready=%b expected 0 0 0",
                     bus.ic_ready, bus.ic_last, bus.dm_ready);
        end
        bus.mem_ready = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_dm_read();
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h0000_0104;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL dmrd_latency0: mem_req=%b expected 0", bus.mem_req);
        end
        cyc();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h104 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL dmrd_issue: req=%b addr=%h we=%b expected 1 00000104 0",
                     bus.mem_req, bus.mem_addr, bus.mem_we);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.dm_ready !== 1'b1 || bus.dm_rdata !== 32'hDEAD_BEEF || bus.ic_ready !== 1'b0) begin
            errors++;
            $display("FAIL dmrd_done: dm_ready=%b dm_rdata=%h ic_ready=%b expected 1 deadbeef 0",
                     bus.dm_ready, bus.dm_rdata, bus.ic_ready);
        end
        cyc();
        bus.dm_req    = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.dm_ready !== 1'b0) begin
            errors++;
            $display("FAIL dmrd_release: mem_req=%b dm_ready=%b expected 0 0", bus.mem_req, bus.dm_ready);
        end
        cyc();
    endtask

    task automatic test_ic_fill();
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_0238;
        cyc();
        for (int b = 0; b < 4; b++) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = 32'hA000_0000 + 32'(b);
            #1;
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h230 + 32'(4 * b)) begin
                errors++;
                $display("FAIL fill_addr[%0d]: req=%b addr=%h expected 1 %h",
                         b, bus.mem_req, bus.mem_addr, 32'h230 + 32'(4 * b));
            end
            checks++;
            if (bus.ic_ready !== 1'b1 || bus.ic_beat !== 2'(b) || bus.ic_last !== (b == 3) ||
                bus.ic_rdata !== 32'hA000_0000 + 32'(b)) begin
                errors++;
                $display("FAIL fill_beat[%0d]: ready=%b beat=%0d last=%b rdata=%h expected 1 %0d %b %h",
                         b, bus.ic_ready, bus.ic_beat, bus.ic_last, bus.ic_rdata,
                         b, (b == 3), 32'hA000_0000 + 32'(b));
            end
            cyc();
        end
        bus.ic_req    = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.ic_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_end: mem_req=%b ic_ready=%b expected 0 0", bus.mem_req, bus.ic_ready);
        end
        cyc();
    endtask

    task automatic test_contention();
        apply_reset();
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_0400;
        bus.dm_req  = 1'b1;
        bus.dm_addr = 32'h0000_0300;
        for (int round = 0; round < 2; round++) begin
            cyc();
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h400) begin
                errors++;
                $display("FAIL cont_ic_first[%0d]: req=%b addr=%h expected 1 00000400",
                         round, bus.mem_req, bus.mem_addr);
            end
            bus.mem_ready = 1'b1;
            for (int b = 0; b < 4; b++) cyc();
            bus.ic_req    = 1'b0;
            bus.mem_ready = 1'b0;
            #1;
            checks++;
            if (bus.mem_req !== 1'b0) begin
                errors++;
                $display("FAIL cont_gap[%0d]: mem_req=%b expected 0", round, bus.mem_req);
            end
            cyc();
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300) begin
                errors++;
                $display("FAIL cont_dm_next[%0d]: req=%b addr=%h expected 1 00000300",
                         round, bus.mem_req, bus.mem_addr);
            end
            bus.mem_ready = 1'b1;
            #1;
            checks++;
            if (bus.dm_ready !== 1'b1) begin
                errors++;
                $display("FAIL cont_dm_done[%0d]: dm_ready=%b expected 1", round, bus.dm_ready);
            end
            cyc();
            bus.mem_ready = 1'b0;
            // Both requesters contend again; IC must win since DM was served last.
            bus.ic_req = 1'b1;
        end
        bus.ic_req = 1'b0;
        bus.dm_req = 1'b0;
        cyc();
    endtask

    task automatic test_dm_write();
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 32'h0000_0052;
        bus.dm_wdata = 32'h1234_5678;
        bus.dm_wstrb = 4'b0011;
        cyc();
        bus.dm_wdata = 32'hFFFF_FFFF;
        bus.dm_wstrb = 4'b1111;
        for (int w = 0; w < 3; w++) begin
            #1;
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wstrb !== 4'b0011 ||
                bus.mem_wdata !== 32'h1234_5678 || bus.mem_addr !== 32'h50 || bus.dm_ready !== 1'b0) begin
                errors++;
                $display("FAIL wr_hold[%0d]: req=%b we=%b strb=%b wdata=%h addr=%h dm_ready=%b expected 1 1 0011 12345678 00000050 0",
                         w, bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_wdata, bus.mem_addr, bus.dm_ready);
            end
            cyc();
        end
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (bus.dm_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_done: dm_ready=%b expected 1", bus.dm_ready);
        end
        cyc();
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL wr_release: mem_req=%b expected 0", bus.mem_req);
        end
        cyc();
    endtask

    task automatic test_reset_mid_fill();
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h0000_1238;
        cyc();
        bus.mem_ready = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.ic_ready !== 1'b0 || bus.ic_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: req=%b addr=%h ic_ready=%b ic_last=%b expected 0 0 0 0",
                     bus.mem_req, bus.mem_addr, bus.ic_ready, bus.ic_last);
        end
        cyc();
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;
        cyc();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h1230) begin
            errors++;
            $display("FAIL rst_restart: req=%b addr=%h expected 1 00001230", bus.mem_req, bus.mem_addr);
        end
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (bus.ic_ready !== 1'b1 || bus.ic_beat !== 2'd0) begin
            errors++;
            $display("FAIL rst_beat0: ic_ready=%b ic_beat=%0d expected 1 0", bus.ic_ready, bus.ic_beat);
        end
        for (int b = 0; b < 4; b++) cyc();
        bus.ic_req    = 1'b0;
        bus.mem_ready = 1'b0;
        cyc();
    endtask

    task automatic test_stray_and_drop();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0BAD_0BAD;
        #1;
        checks++;
        if (bus.ic_ready !== 1'b0 || bus.dm_ready !== 1'b0) begin
            errors++;
            $display("FAIL stray_ready: ic_ready=%b dm_ready=%b expected 0 0", bus.ic_ready, bus.dm_ready);
        end
        cyc();
        checks++;
        if (bus.mem_req !== 1'b0 || bus.ic_ready !== 1'b0 || bus.dm_ready !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle: mem_req=%b ic_ready=%b dm_ready=%b expected 0 0 0",
                     bus.mem_req, bus.ic_ready, bus.dm_ready);
        end
        bus.mem_ready = 1'b0;
        bus.dm_req    = 1'b1;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = 32'h0000_0008;
        cyc();
        bus.dm_req = 1'b0;
        cyc();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8 || bus.dm_ready !== 1'b0) begin
            errors++;
            $display("FAIL drop_hold: req=%b addr=%h dm_ready=%b expected 1 00000008 0",
                     bus.mem_req, bus.mem_addr, bus.dm_ready);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_0055;
        #1;
        checks++;
        if (bus.dm_ready !== 1'b1 || bus.dm_rdata !== 32'h55) begin
            errors++;
            $display("FAIL drop_done: dm_ready=%b dm_rdata=%h expected 1 00000055", bus.dm_ready, bus.dm_rdata);
        end
        cyc();
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.dm_ready !== 1'b0) begin
            errors++;
            $display("FAIL drop_release: mem_req=%b dm_ready=%b expected 0 0", bus.mem_req, bus.dm_ready);
        end
        cyc();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_dm_read();
        test_ic_fill();
        test_contention();
        test_dm_write();
        test_reset_mid_fill();
        test_stray_and_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
